// File: rtl/vga_pkg.sv
// 640x480@60 raster timing constants shared by the VGA output stage.
package vga_pkg;

    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FP     = 16;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BP     = 48;
    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FP     = 10;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BP     = 33;

    localparam bit VGA_HS_POL = 1'b0;
    localparam bit VGA_VS_POL = 1'b0;

    localparam int unsigned VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int unsigned VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
    localparam int unsigned VGA_HS_START = VGA_H_ACTIVE + VGA_H_FP;
    localparam int unsigned VGA_HS_END   = VGA_HS_START + VGA_H_SYNC;
    localparam int unsigned VGA_VS_START = VGA_V_ACTIVE + VGA_V_FP;
    localparam int unsigned VGA_VS_END   = VGA_VS_START + VGA_V_SYNC;

    // Active-high timing flags carried through the alignment delay line.
    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
    } sync_t;

endpackage

// File: rtl/vga_delay_line.sv
// Shift register of DEPTH stages with asynchronous clear; a plain wire when DEPTH is 0.
module vga_delay_line #(
    parameter int unsigned W     = 3,
    parameter int unsigned DEPTH = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    if (DEPTH == 0) begin : g_wire
        assign q = d;
    end else begin : g_shift
        logic [DEPTH-1:0][W-1:0] stage_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                stage_q <= '0;
            end else begin
                stage_q[0] <= d;
                for (int i = 1; i < DEPTH; i++) begin
                    stage_q[i] <= stage_q[i-1];
                end
            end
        end

        assign q = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/vga_sync_out.sv
// VGA raster timing generator and pin register; sync/de are delayed to match upstream colour.
module vga_sync_out
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
    parameter int unsigned H_FP     = VGA_H_FP,
    parameter int unsigned H_SYNC   = VGA_H_SYNC,
    parameter int unsigned H_BP     = VGA_H_BP,
    parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
    parameter int unsigned V_FP     = VGA_V_FP,
    parameter int unsigned V_SYNC   = VGA_V_SYNC,
    parameter int unsigned V_BP     = VGA_V_BP,
    parameter bit          HS_POL   = VGA_HS_POL,
    parameter bit          VS_POL   = VGA_VS_POL,
    parameter int unsigned PIPE     = 1,
    parameter int unsigned CW       = 8,
    parameter int unsigned XW       = 11,
    parameter int unsigned YW       = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [CW-1:0] r_in,
    input  logic [CW-1:0] g_in,
    input  logic [CW-1:0] b_in,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          req,
    output logic          frame_start,
    output logic [CW-1:0] vga_r,
    output logic [CW-1:0] vga_g,
    output logic [CW-1:0] vga_b,
    output logic          hsync,
    output logic          vsync,
    output logic          de
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [XW-1:0] H_LAST   = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0] H_ACT    = XW'(H_ACTIVE);
    localparam logic [XW-1:0] HS_START = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] HS_END   = XW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [YW-1:0] V_LAST   = YW'(V_TOTAL - 1);
    localparam logic [YW-1:0] V_ACT    = YW'(V_ACTIVE);
    localparam logic [YW-1:0] VS_START = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0] VS_END   = YW'(V_ACTIVE + V_FP + V_SYNC);

    logic [XW-1:0] hcnt_q, hcnt_d;
    logic [YW-1:0] vcnt_q, vcnt_d;
    sync_t         raw, dly;

    always_comb begin
        hcnt_d = hcnt_q + XW'(1);
        vcnt_d = vcnt_q;
        if (hcnt_q == H_LAST) begin
            hcnt_d = '0;
            vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + YW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
        end
    end

    assign x           = hcnt_q;
    assign y           = vcnt_q;
    assign req         = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
    assign frame_start = (hcnt_q == '0) && (vcnt_q == '0);

    always_comb begin
        raw.hs = (hcnt_q >= HS_START) && (hcnt_q < HS_END);
        raw.vs = (vcnt_q >= VS_START) && (vcnt_q < VS_END);
        raw.de = req;
    end

    // Match the upstream colour latency so timing and pixels meet at the pins.
    vga_delay_line #(
        .W    (3),
        .DEPTH(PIPE)
    ) u_delay (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (raw),
        .q    (dly)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_r <= '0;
            vga_g <= '0;
            vga_b <= '0;
            hsync <= ~HS_POL;
            vsync <= ~VS_POL;
            de    <= 1'b0;
        end else begin
            vga_r <= dly.de ? r_in : '0;
            vga_g <= dly.de ? g_in : '0;
            vga_b <= dly.de ? b_in : '0;
            hsync <= dly.hs ? HS_POL : ~HS_POL;
            vsync <= dly.vs ? VS_POL : ~VS_POL;
            de    <= dly.de;
        end
    end

endmodule

// File: tb/tb_vga_sync_out.sv
// Bench for vga_sync_out: default timing with random colour, plus PIPE=0/3 with an x-driven upstream.
module tb_vga_sync_out;

    localparam int HT  = 800;
    localparam int HA  = 640;
    localparam int HS0 = 656;
    localparam int HS1 = 752;

    localparam int DEF_VA  = 480;
    localparam int DEF_VFP = 10;
    localparam int DEF_VT  = 525;
    localparam int SM_VA   = 4;
    localparam int SM_VFP  = 1;
    localparam int SM_VT   = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  d_r, d_g, d_b, d_vr, d_vg, d_vb;
    logic [10:0] d_x;
    logic [9:0]  d_y;
    logic        d_req, d_fs, d_hs, d_vs, d_de;

    logic [7:0]  p0_r, p0_g, p0_b, p0_vr, p0_vg, p0_vb;
    logic [10:0] p0_x;
    logic [9:0]  p0_y;
    logic        p0_req, p0_fs, p0_hs, p0_vs, p0_de;

    logic [7:0]  p3_r, p3_g, p3_b, p3_vr, p3_vg, p3_vb;
    logic [10:0] p3_x;
    logic [9:0]  p3_y;
    logic        p3_req, p3_fs, p3_hs, p3_vs, p3_de;
    logic [7:0]  p3_hist [3];

    vga_sync_out u_def (
        .clk(clk), .rst_n(rst_n), .r_in(d_r), .g_in(d_g), .b_in(d_b),
        .x(d_x), .y(d_y), .req(d_req), .frame_start(d_fs),
        .vga_r(d_vr), .vga_g(d_vg), .vga_b(d_vb), .hsync(d_hs), .vsync(d_vs), .de(d_de)
    );

    vga_sync_out #(
        .V_ACTIVE(SM_VA), .V_FP(SM_VFP), .V_SYNC(2), .V_BP(1), .PIPE(0)
    ) u_p0 (
        .clk(clk), .rst_n(rst_n), .r_in(p0_r), .g_in(p0_g), .b_in(p0_b),
        .x(p0_x), .y(p0_y), .req(p0_req), .frame_start(p0_fs),
        .vga_r(p0_vr), .vga_g(p0_vg), .vga_b(p0_vb), .hsync(p0_hs), .vsync(p0_vs), .de(p0_de)
    );

    vga_sync_out #(
        .V_ACTIVE(SM_VA), .V_FP(SM_VFP), .V_SYNC(2), .V_BP(1), .PIPE(3)
    ) u_p3 (
        .clk(clk), .rst_n(rst_n), .r_in(p3_r), .g_in(p3_g), .b_in(p3_b),
        .x(p3_x), .y(p3_y), .req(p3_req), .frame_start(p3_fs),
        .vga_r(p3_vr), .vga_g(p3_vg), .vga_b(p3_vb), .hsync(p3_hs), .vsync(p3_vs), .de(p3_de)
    );

    // Upstream models: colour = x[7:0] returned after PIPE clocks.
    assign p0_r = p0_x[7:0];
    assign p0_g = p0_r;
    assign p0_b = ~p0_r;

    always @(posedge clk) begin
        p3_hist[0] <= p3_x[7:0];
        p3_hist[1] <= p3_hist[0];
        p3_hist[2] <= p3_hist[1];
    end
    assign p3_r = p3_hist[2];
    assign p3_g = p3_r;
    assign p3_b = ~p3_r;

    int vectors = 0;
    int miscompares = 0;
    logic [23:0] d_applied = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected behaviour after m clock edges since reset release.
    task automatic check_inst(input string name, input int pipe, input int vt, input int va,
                              input int vfp, input bit from_x, input int m,
                              input logic [31:0] x, input logic [31:0] y, input logic req,
                              input logic fs, input logic hs, input logic vs, input logic de,
                              input logic [23:0] rgb);
        int h, v, idx, hi, vi;
        logic e_de, e_hs, e_vs;
        logic [23:0] e_rgb;
        logic [7:0] c;
        h = m % HT;
        v = (m / HT) % vt;
        check_eq({name, ".x"}, x, 32'(h));
        check_eq({name, ".y"}, y, 32'(v));
        check_eq({name, ".req"}, 32'(req), 32'((h < HA) && (v < va)));
        check_eq({name, ".frame_start"}, 32'(fs), 32'((h == 0) && (v == 0)));
        idx = m - pipe - 1;
        e_de = 1'b0; e_hs = 1'b1; e_vs = 1'b1; e_rgb = '0;
        if (idx >= 0) begin
            hi = idx % HT;
            vi = (idx / HT) % vt;
            e_de = (hi < HA) && (vi < va);
            e_hs = !((hi >= HS0) && (hi < HS1));
            e_vs = !((vi >= va + vfp) && (vi < va + vfp + 2));
            c = 8'(hi % 256);
            if (e_de) e_rgb = from_x ? {c, c, ~c} : d_applied;
        end
        check_eq({name, ".de"}, 32'(de), 32'(e_de));
        check_eq({name, ".hsync"}, 32'(hs), 32'(e_hs));
        check_eq({name, ".vsync"}, 32'(vs), 32'(e_vs));
        check_eq({name, ".rgb"}, 32'(rgb), 32'(e_rgb));
    endtask

    task automatic check_all(input int m);
        check_inst("def", 1, DEF_VT, DEF_VA, DEF_VFP, 1'b0, m, 32'(d_x), 32'(d_y), d_req, d_fs,
                   d_hs, d_vs, d_de, {d_vr, d_vg, d_vb});
        check_inst("p0", 0, SM_VT, SM_VA, SM_VFP, 1'b1, m, 32'(p0_x), 32'(p0_y), p0_req, p0_fs,
                   p0_hs, p0_vs, p0_de, {p0_vr, p0_vg, p0_vb});
        check_inst("p3", 3, SM_VT, SM_VA, SM_VFP, 1'b1, m, 32'(p3_x), 32'(p3_y), p3_req, p3_fs,
                   p3_hs, p3_vs, p3_de, {p3_vr, p3_vg, p3_vb});
    endtask

    task automatic drive_colour(input int m);
        logic [23:0] rgb;
        rgb = 24'($urandom);
        if (m >= 3000 && m < 5000) rgb = 24'hFFFFFF;
        d_r = rgb[23:16];
        d_g = rgb[15:8];
        d_b = rgb[7:0];
        d_applied = rgb;
    endtask

    initial begin
        int  m;
        bit  did_rst;
        m = 0;
        did_rst = 1'b0;
        drive_colour(0);
        repeat (3) @(negedge clk);
        check_all(0);
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 30000; cyc++) begin
            @(posedge clk);
            m++;
            @(negedge clk);
            check_all(m);
            // Mid-line reset on the default raster at hcnt=300 of line 1.
            if (!did_rst && m == 1100) begin
                did_rst = 1'b1;
                #2 rst_n = 1'b0;
                #1 check_all(0);
                repeat (3) begin
                    @(negedge clk);
                    check_all(0);
                end
                rst_n = 1'b1;
                m = 0;
            end
            drive_colour(m);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
